// File: rtl/slow_mmio_bridge.sv
// Fast-clock MMIO bridge: captures one CPU access per slow period on the slow
// falling edge and runs a req/ack handshake with a bounded wait.
module slow_mmio_bridge #(
    parameter int FREQ_MHZ = 10
) (
    input  logic        clk_100MHz,
    input  logic        reset,
    input  logic        clk_slow,
    input  logic        cpu_we,
    input  logic        cpu_re,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_err,
    output logic        busy,
    output logic        periph_req,
    output logic        periph_we,
    output logic [31:0] periph_addr,
    output logic [31:0] periph_wdata,
    input  logic        periph_ack,
    input  logic [31:0] periph_rdata
);
    localparam int HALF    = 100 / (2 * FREQ_MHZ);
    localparam int TIMEOUT = HALF - 2;
    localparam int TCNT_W  = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, REQ} state_t;

    state_t              state, state_n;
    logic                clk_slow_q;
    logic [TCNT_W-1:0]   tcnt, tcnt_n;
    logic [31:0]         rdata_n, paddr_n, pwdata_n;
    logic                err_n, pwe_n;
    logic                fall;

    // clk_slow is generated from clk_100MHz, so it is sampled directly as data
    assign fall       = clk_slow_q & ~clk_slow;
    assign periph_req = (state == REQ);
    assign busy       = (state == REQ);

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            clk_slow_q   <= 1'b0;
            tcnt         <= '0;
            cpu_rdata    <= '0;
            cpu_err      <= 1'b0;
            periph_we    <= 1'b0;
            periph_addr  <= '0;
            periph_wdata <= '0;
        end else begin
            state        <= state_n;
            clk_slow_q   <= clk_slow;
            tcnt         <= tcnt_n;
            cpu_rdata    <= rdata_n;
            cpu_err      <= err_n;
            periph_we    <= pwe_n;
            periph_addr  <= paddr_n;
            periph_wdata <= pwdata_n;
        end
    end

    always_comb begin
        state_n  = state;
        tcnt_n   = tcnt;
        rdata_n  = cpu_rdata;
        err_n    = cpu_err;
        pwe_n    = periph_we;
        paddr_n  = periph_addr;
        pwdata_n = periph_wdata;
        case (state)
            IDLE: begin
                // store wins when both strobes are set
                if (fall && (cpu_we || cpu_re)) begin
                    pwe_n    = cpu_we;
                    paddr_n  = cpu_addr;
                    pwdata_n = cpu_wdata;
                    err_n    = 1'b0;
                    tcnt_n   = '0;
                    state_n  = REQ;
                end
            end
            REQ: begin
                if (periph_ack) begin
                    if (!periph_we) rdata_n = periph_rdata;
                    state_n = IDLE;
                end else if (tcnt == TCNT_W'(TIMEOUT - 1)) begin
                    err_n = 1'b1;
                    if (!periph_we) rdata_n = '0;
                    state_n = IDLE;
                end else begin
                    tcnt_n = tcnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_slow_mmio_bridge.sv
// Directed bench for slow_mmio_bridge at FREQ_MHZ=10 (HALF=5, TIMEOUT=3).
module tb_slow_mmio_bridge;
    localparam int HALF = 5;

    logic        clk_100MHz = 1'b0;
    logic        reset;
    logic        clk_slow;
    logic        cpu_we, cpu_re;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_err, busy, periph_req, periph_we;
    logic [31:0] periph_addr, periph_wdata;
    logic        periph_ack;
    logic [31:0] periph_rdata;

    int n_total = 0;
    int n_pass  = 0;

    slow_mmio_bridge #(.FREQ_MHZ(10)) dut (
        .clk_100MHz  (clk_100MHz),
        .reset       (reset),
        .clk_slow    (clk_slow),
        .cpu_we      (cpu_we),
        .cpu_re      (cpu_re),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_err     (cpu_err),
        .busy        (busy),
        .periph_req  (periph_req),
        .periph_we   (periph_we),
        .periph_addr (periph_addr),
        .periph_wdata(periph_wdata),
        .periph_ack  (periph_ack),
        .periph_rdata(periph_rdata)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    typedef struct {
        logic        we, re;
        logic [31:0] addr, wdata, prd;
        int          ack_cyc;   // 0 = never ack
        int          ereq;
        logic        epwe;
        logic [31:0] eaddr, ewdata, erd;
        logic        eerr;
    } vec_t;

    vec_t v[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_100MHz);
        #1;
    endtask

    // after this returns we are just past edge F
    task automatic do_fall();
        clk_slow = 1'b1;
        tick();
        clk_slow = 1'b0;
        tick();
    endtask

    initial begin
        int n;
        reset = 1'b1; clk_slow = 1'b0; cpu_we = 0; cpu_re = 0;
        cpu_addr = '0; cpu_wdata = '0; periph_ack = 0; periph_rdata = '0;
        #1;
        chk("rst_rdata", cpu_rdata, 32'h0);
        chk("rst_req", {31'b0, periph_req}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_err", {31'b0, cpu_err}, 32'h0);
        chk("rst_paddr", periph_addr, 32'h0);

        // clk_slow_q must reset to 0: high->low across reset release is not a fall
        clk_slow = 1'b1;
        tick(); tick();
        clk_slow = 1'b0; cpu_re = 1'b1; cpu_addr = 32'h1234_0000;
        reset = 1'b0;
        tick();
        chk("rst_no_fall", {31'b0, periph_req}, 32'h0);
        tick();
        chk("rst_no_fall2", {31'b0, busy}, 32'h0);
        cpu_re = 1'b0;
        tick();

        v[0] = '{1'b0,1'b1,32'h1000_0004,32'h0,        32'hCAFE_F00D,1,1,1'b0,32'h1000_0004,32'h0,        32'hCAFE_F00D,1'b0};
        v[1] = '{1'b1,1'b0,32'h2000_0010,32'h0000_00A5,32'hDEAD_BEEF,2,2,1'b1,32'h2000_0010,32'h0000_00A5,32'hCAFE_F00D,1'b0};
        v[2] = '{1'b0,1'b1,32'h1000_0008,32'h0,        32'h1234_5678,0,3,1'b0,32'h1000_0008,32'h0,        32'h0,        1'b1};
        v[3] = '{1'b0,1'b1,32'h1000_000C,32'h0,        32'h5555_AAAA,3,3,1'b0,32'h1000_000C,32'h0,        32'h5555_AAAA,1'b0};
        v[4] = '{1'b1,1'b1,32'h3000_0000,32'h0000_0077,32'h0BAD_0BAD,1,1,1'b1,32'h3000_0000,32'h0000_0077,32'h5555_AAAA,1'b0};
        v[5] = '{1'b0,1'b0,32'h4444_4444,32'h0000_9999,32'hFFFF_FFFF,1,0,1'b1,32'h3000_0000,32'h0000_0077,32'h5555_AAAA,1'b0};
        v[6] = '{1'b0,1'b1,32'h1000_0010,32'h0,        32'h0,        0,3,1'b0,32'h1000_0010,32'h0,        32'h0,        1'b1};
        v[7] = '{1'b0,1'b0,32'h5000_0000,32'h0000_0001,32'h0,        0,0,1'b0,32'h1000_0010,32'h0,        32'h0,        1'b1};
        v[8] = '{1'b0,1'b1,32'h1000_0014,32'h0,        32'h600D_600D,2,2,1'b0,32'h1000_0014,32'h0,        32'h600D_600D,1'b0};

        for (int i = 0; i < 9; i++) begin
            cpu_we = v[i].we; cpu_re = v[i].re;
            cpu_addr = v[i].addr; cpu_wdata = v[i].wdata;
            do_fall();
            n = 0;
            for (int c = 1; c <= HALF + 1; c++) begin
                if (periph_req) n++;
                periph_ack   = (c == v[i].ack_cyc);
                periph_rdata = v[i].prd;
                tick();
            end
            periph_ack = 1'b0;
            chk($sformatf("v%0d_reqcyc", i), n, v[i].ereq);
            chk($sformatf("v%0d_pwe", i), {31'b0, periph_we}, {31'b0, v[i].epwe});
            chk($sformatf("v%0d_paddr", i), periph_addr, v[i].eaddr);
            chk($sformatf("v%0d_pwdata", i), periph_wdata, v[i].ewdata);
            chk($sformatf("v%0d_rdata", i), cpu_rdata, v[i].erd);
            chk($sformatf("v%0d_err", i), {31'b0, cpu_err}, {31'b0, v[i].eerr});
            chk($sformatf("v%0d_busy", i), {31'b0, busy}, 32'h0);
        end

        // zero-wait read: req in F+1 only, result visible at F+2
        cpu_we = 0; cpu_re = 1; cpu_addr = 32'h1000_0020;
        do_fall();
        chk("zw_req_f1", {31'b0, periph_req}, 32'h1);
        chk("zw_rdata_f1", cpu_rdata, 32'h600D_600D);
        periph_ack = 1'b1; periph_rdata = 32'hA1B2_C3D4;
        tick();
        periph_ack = 1'b0;
        chk("zw_req_f2", {31'b0, periph_req}, 32'h0);
        chk("zw_rdata_f2", cpu_rdata, 32'hA1B2_C3D4);
        tick(); tick();

        // timeout timing: req F+1..F+3, err visible at F+4
        cpu_addr = 32'h1000_0024;
        do_fall();
        chk("to_req_f1", {31'b0, periph_req}, 32'h1);
        tick();
        chk("to_req_f2", {31'b0, periph_req}, 32'h1);
        tick();
        chk("to_req_f3", {31'b0, periph_req}, 32'h1);
        chk("to_err_f3", {31'b0, cpu_err}, 32'h0);
        tick();
        chk("to_req_f4", {31'b0, periph_req}, 32'h0);
        chk("to_err_f4", {31'b0, cpu_err}, 32'h1);
        chk("to_rdata_f4", cpu_rdata, 32'h0);
        tick();

        // restore non-zero rdata, then reset mid-REQ
        cpu_addr = 32'h1000_0028;
        do_fall();
        periph_ack = 1'b1; periph_rdata = 32'h1111_2222;
        tick();
        periph_ack = 1'b0;
        chk("pre_rst_rdata", cpu_rdata, 32'h1111_2222);
        tick();
        cpu_we = 1; cpu_re = 0; cpu_addr = 32'h2000_0040; cpu_wdata = 32'h0000_00EE;
        do_fall();
        tick();
        chk("mid_busy", {31'b0, busy}, 32'h1);
        #3 reset = 1'b1;
        #1;
        chk("mr_req", {31'b0, periph_req}, 32'h0);
        chk("mr_rdata", cpu_rdata, 32'h0);
        chk("mr_pwe", {31'b0, periph_we}, 32'h0);
        chk("mr_paddr", periph_addr, 32'h0);
        chk("mr_pwdata", periph_wdata, 32'h0);
        cpu_we = 0;
        tick();
        reset = 1'b0;
        periph_ack = 1'b1; periph_rdata = 32'hBADB_ADBA;
        tick();
        periph_ack = 1'b0;
        chk("late_ack_rdata", cpu_rdata, 32'h0);
        chk("late_ack_req", {31'b0, periph_req}, 32'h0);
        do_fall();
        chk("idle_fall_req", {31'b0, periph_req}, 32'h0);
        tick();
        chk("idle_fall_err", {31'b0, cpu_err}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
